// File: rtl/fc_layer_core_if.sv
// Operand/result bus and start/done handshake between the layer controller and fc_layer_core.
interface fc_layer_core_if #(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 2,
    parameter int DATA_WIDTH  = 16
);
    logic                                     start;
    logic                                     done;
    logic [INPUT_SIZE*DATA_WIDTH-1:0]         input_data_flat;
    logic [OUTPUT_SIZE*INPUT_SIZE*DATA_WIDTH-1:0] weights_flat;
    logic [OUTPUT_SIZE*DATA_WIDTH-1:0]        bias_flat;
    logic [OUTPUT_SIZE*DATA_WIDTH-1:0]        output_data_flat;

    modport master (
        output start, input_data_flat, weights_flat, bias_flat,
        input  done, output_data_flat
    );

    modport slave (
        input  start, input_data_flat, weights_flat, bias_flat,
        output done, output_data_flat
    );
endinterface

// File: rtl/fc_layer_core.sv
// Sequential dense layer y[o] = sat(sum_i x[i]*W[o][i] + b[o]), one MAC per clock.
// Define FC_LAYER_RELU_EN to clamp negative outputs to zero after saturation.
module fc_layer_core #(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 2,
    parameter int DATA_WIDTH  = 16
) (
    input  logic           clk,
    input  logic           reset,
    fc_layer_core_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW;
    localparam int NW = OUTPUT_SIZE * INPUT_SIZE;
    localparam int AW = PW + $clog2(INPUT_SIZE) + 1;
    localparam int IW = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
    localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUTPUT_SIZE - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_DONE} state_t;

    state_t state, state_n;
    logic   load, mac_en, bias_en;

    logic signed [DW-1:0] x_r [INPUT_SIZE];
    logic signed [DW-1:0] w_r [NW];
    logic signed [DW-1:0] b_r [OUTPUT_SIZE];
    logic signed [DW-1:0] y_r [OUTPUT_SIZE];
    logic [IW-1:0]        i_cnt;
    logic [OW-1:0]        o_cnt;
    logic [WW-1:0]        w_idx;
    logic                 done_r;

    logic signed [PW-1:0] prod_p0;
    logic signed [AW-1:0] prod_ext_p0, bias_ext_p0, biased_p0;
    logic signed [AW-1:0] acc_p1;

    function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DW-1:0];
        if (v < SAT_MIN) return SAT_MIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] activate(input logic signed [DW-1:0] v);
`ifdef FC_LAYER_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Stage p0: product of the current operand pair and the biased accumulator.
    always_comb begin
        prod_p0     = PW'(x_r[i_cnt]) * PW'(w_r[w_idx]);
        prod_ext_p0 = AW'(prod_p0);
        bias_ext_p0 = AW'(b_r[o_cnt]);
        biased_p0   = acc_p1 + bias_ext_p0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        mac_en  = 1'b0;
        bias_en = 1'b0;
        case (state)
            S_IDLE: if (bus.start) begin
                load    = 1'b1;
                state_n = S_MAC;
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (i_cnt == I_LAST) state_n = S_BIAS;
            end
            S_BIAS: begin
                bias_en = 1'b1;
                state_n = (o_cnt == O_LAST) ? S_DONE : S_MAC;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Stage p1: operand capture, accumulation and per-neuron write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < INPUT_SIZE;  k++) x_r[k] <= '0;
            for (int k = 0; k < NW;          k++) w_r[k] <= '0;
            for (int k = 0; k < OUTPUT_SIZE; k++) b_r[k] <= '0;
            for (int k = 0; k < OUTPUT_SIZE; k++) y_r[k] <= '0;
            acc_p1 <= '0;
            i_cnt  <= '0;
            o_cnt  <= '0;
            w_idx  <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state == S_DONE);
            if (load) begin
                for (int k = 0; k < INPUT_SIZE;  k++) x_r[k] <= bus.input_data_flat[k*DW +: DW];
                for (int k = 0; k < NW;          k++) w_r[k] <= bus.weights_flat[k*DW +: DW];
                for (int k = 0; k < OUTPUT_SIZE; k++) b_r[k] <= bus.bias_flat[k*DW +: DW];
                acc_p1 <= '0;
                i_cnt  <= '0;
                o_cnt  <= '0;
                w_idx  <= '0;
            end
            if (mac_en) begin
                acc_p1 <= acc_p1 + prod_ext_p0;
                i_cnt  <= i_cnt + IW'(1);
                w_idx  <= w_idx + WW'(1);
            end
            if (bias_en) begin
                y_r[o_cnt] <= activate(sat(biased_p0));
                acc_p1     <= '0;
                i_cnt      <= '0;
                if (o_cnt != O_LAST) o_cnt <= o_cnt + OW'(1);
            end
        end
    end

    for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_out
        assign bus.output_data_flat[g*DW +: DW] = y_r[g];
    end
    assign bus.done = done_r;
endmodule

// File: tb/tb_fc_layer_core.sv
// Table-driven bench for fc_layer_core with a result scoreboard and multi-cycle corner sequences.
module tb_fc_layer_core;
    localparam int LAT = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fc_layer_core_if #(.INPUT_SIZE(4), .OUTPUT_SIZE(2), .DATA_WIDTH(16)) bus ();

    fc_layer_core #(.INPUT_SIZE(4), .OUTPUT_SIZE(2), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        logic [63:0]  x;
        logic [127:0] w;
        logic [31:0]  b;
        logic [31:0]  y;
    } vec_t;

    vec_t         tbl [7];
    logic [31:0]  sb [$];
    int           total  = 0;
    int           passed = 0;

    function automatic logic [63:0] p4(int a0, int a1, int a2, int a3);
        return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    endfunction

    function automatic logic [31:0] p2(int a0, int a1);
        return {a1[15:0], a0[15:0]};
    endfunction

    function automatic int r(int v);
`ifdef FC_LAYER_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(int k);
        bus.input_data_flat = tbl[k].x;
        bus.weights_flat    = tbl[k].w;
        bus.bias_flat       = tbl[k].b;
    endtask

    task automatic launch(int k);
        drive(k);
        bus.start = 1'b1;
        sb.push_back(tbl[k].y);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.done && cyc < 60);
    endtask

    task automatic compare_out(string nm);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            check({nm, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        exp = sb.pop_front();
        check({nm, "_y0"}, {16'd0, bus.output_data_flat[15:0]},  {16'd0, exp[15:0]});
        check({nm, "_y1"}, {16'd0, bus.output_data_flat[31:16]}, {16'd0, exp[31:16]});
    endtask

    task automatic run_one(int k, string nm);
        int cyc;
        launch(k);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(cyc);
        check({nm, "_latency"}, cyc, LAT);
        compare_out(nm);
    endtask

    initial begin
        int cyc, cyc2, ndone;
        logic [31:0] held;

        tbl[0] = '{"basic",  p4(1,2,3,4), {p4(1,1,1,1), p4(2,2,2,2)}, p2(5,0), p2(25,10)};
        tbl[1] = '{"neg",    p4(-1,-2,-3,-4), {p4(1,1,1,1), p4(1,1,1,1)}, p2(0,0), p2(r(-10), r(-10))};
        tbl[2] = '{"satpos", p4(32767,32767,32767,32767),
                   {p4(32767,32767,32767,32767), p4(32767,32767,32767,32767)},
                   p2(32767,32767), p2(32767,32767)};
        tbl[3] = '{"satneg", p4(32767,32767,32767,32767),
                   {p4(-32767,-32767,-32767,-32767), p4(-32767,-32767,-32767,-32767)},
                   p2(32767,32767), p2(r(-32768), r(-32768))};
        tbl[4] = '{"mixed",  p4(100,-200,300,-400), {p4(4,-3,2,-1), p4(1,1,1,1)},
                   p2(7,-7), p2(r(-193), 1993)};
        tbl[5] = '{"edgemax", p4(32767,1,0,0), {p4(1,1,1,1), p4(1,1,1,1)},
                   p2(0,-1), p2(32767,32767)};
        tbl[6] = '{"edgemin", p4(-32768,0,0,0), {p4(1,1,1,1), p4(1,1,1,1)},
                   p2(0,-1), p2(r(-32768), r(-32768))};

        reset     = 1'b1;
        bus.start = 1'b0;
        drive(0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_out",  bus.output_data_flat, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) run_one(k, tbl[k].name);

        // Operand buses change mid-run; result must come from the captured values.
        launch(0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(2);
        wait_done(cyc);
        check("latch_latency", cyc + 2, LAT);
        compare_out("latch");

        // Start pulses while busy are ignored: one done pulse only.
        launch(4);
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
            if (c == 11) held = bus.output_data_flat;
            bus.start = (c == 3 || c == 9);
        end
        bus.start = 1'b0;
        check("busy_start_ndone", ndone, 1);
        compare_out("busy_start");
        check("busy_start_hold", bus.output_data_flat, held);

        // Reset mid-MAC aborts the run and clears the outputs.
        launch(0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_out",  bus.output_data_flat, 32'd0);
        void'(sb.pop_front());
        @(posedge clk); #1;
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_out_held", bus.output_data_flat, 32'd0);
        run_one(4, "after_abort");

        // Start held high: back-to-back runs, next one sampled the cycle after DONE.
        launch(0);
        sb.push_back(tbl[0].y);
        @(posedge clk); #1;
        wait_done(cyc);
        check("b2b_lat1", cyc, LAT);
        compare_out("b2b_run1");
        wait_done(cyc2);
        bus.start = 1'b0;
        check("b2b_lat2", cyc2, LAT + 1);
        compare_out("b2b_run2");
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("idle_no_done", ndone, 0);
        check("idle_hold", bus.output_data_flat, tbl[0].y);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
